mem_arb: RTL

//  Shares the single external memory port between the instruction-fetch refill

---
 rtl/mem_arb_pkg.sv | 17 +
 rtl/mem_arb_if.sv | 33 +++
 rtl/mem_arb_burst_cnt.sv | 45 ++++
 rtl/mem_arb.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared defaults and types for the memory-port arbiter.
// Holds the default bus/line geometry and the arbiter state encoding.
package mem_arb_pkg;

    localparam int unsigned ADDR_W_DEF     = 64;
    localparam int unsigned DATA_W_DEF     = 64;
    localparam int unsigned LINE_BEATS_DEF = 8;

    // Arbiter states: idle/grant, I refill read, D line read, D write-back.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_I_RD = 2'd1,
        ST_D_RD = 2'd2,
        ST_D_WR = 2'd3
    } state_e;

endpackage

// File: rtl/mem_arb_if.sv
// External memory bus between the arbiter (master) and the memory slave.
// Ports carried:
//   m_addr  master->slave  beat byte address
//   m_rd    master->slave  read strobe, held for the whole burst
//   m_wr    master->slave  write strobe, held for the whole burst
//   m_wdata master->slave  write beat data
//   m_rdata slave->master  read beat data
//   m_ack   slave->master  current beat completes this cycle
interface mem_arb_if
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
);

    logic [ADDR_W-1:0] m_addr;
    logic              m_rd;
    logic              m_wr;
    logic [DATA_W-1:0] m_wdata;
    logic [DATA_W-1:0] m_rdata;
    logic              m_ack;

    modport master (
        output m_addr, m_rd, m_wr, m_wdata,
        input  m_rdata, m_ack
    );

    modport slave (
        input  m_addr, m_rd, m_wr, m_wdata,
        output m_rdata, m_ack
    );

endinterface

// File: rtl/mem_arb_burst_cnt.sv
// Beat counter for one line burst.
// Ports:
//   clk, rst_n  clock, async active-low reset
//   inc_i       advance to the next beat (wraps after the last beat)
//   clr_i       force back to beat 0
//   cnt_o       current beat index
//   last_o      current beat is the final beat of the line
module mem_arb_burst_cnt #(
    parameter int unsigned LINE_BEATS = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          inc_i,
    input  logic                          clr_i,
    output logic [$clog2(LINE_BEATS)-1:0] cnt_o,
    output logic                          last_o
);

    localparam int unsigned CNT_W = $clog2(LINE_BEATS);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Power-of-two line length, so plain overflow is the wrap to 0.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign last_o = (cnt_q == CNT_W'(LINE_BEATS - 1));

endmodule

// File: rtl/mem_arb.sv
// Arbiter sharing one external memory port between the I-fetch refill
// requester and the D read/write-back requester. Runs fixed-length line
// bursts, round-robins on ties and produces the pipeline stall (busy) flags.
// Ports:
//   clk, rst_n                     clock, async active-low reset
//   i_req/i_addr                   I refill request and line address
//   i_rdata/i_beat/i_done/i_busy   I read data, beat valid, last beat, busy
//   d_rd/d_wr/d_addr/d_wdata       D read / write-back request, address, write data
//   d_rdata/d_beat/d_done          D read data, beat accepted/valid, last beat
//   d_busy_rd/d_busy_wr            D read / write pending or in service
//   mem                            external memory bus (master side)
module mem_arb
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W     = ADDR_W_DEF,
    parameter int unsigned DATA_W     = DATA_W_DEF,
    parameter int unsigned LINE_BEATS = LINE_BEATS_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_beat,
    output logic              i_done,
    output logic              i_busy,
    input  logic              d_rd,
    input  logic              d_wr,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_beat,
    output logic              d_done,
    output logic              d_busy_rd,
    output logic              d_busy_wr,
    mem_arb_if.master         mem
);

    localparam int unsigned CNT_W  = $clog2(LINE_BEATS);
    localparam int unsigned OFF_W  = $clog2(DATA_W / 8);
    localparam int unsigned LINE_W = CNT_W + OFF_W;
    localparam int unsigned BASE_W = ADDR_W - LINE_W;

    state_e            state_q, state_d;
    logic              last_d_q, last_d_d;
    logic [BASE_W-1:0] base_q, base_d;

    logic [CNT_W-1:0]  cnt;
    logic              cnt_last;
    logic              cnt_inc;
    logic              cnt_clr;
    logic              rd_c;
    logic              wr_c;
    logic              i_pend;
    logic              d_pend;

    // Line offset bits of the request addresses are deliberately dropped.
    logic              unused_offsets;
    assign unused_offsets = ^{i_addr[LINE_W-1:0], d_addr[LINE_W-1:0]};

    assign i_pend = i_req;
    assign d_pend = d_rd | d_wr;

    mem_arb_burst_cnt #(
        .LINE_BEATS (LINE_BEATS)
    ) u_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .inc_i  (cnt_inc),
        .clr_i  (cnt_clr),
        .cnt_o  (cnt),
        .last_o (cnt_last)
    );

    // State, grant history and latched line base.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            last_d_q <= 1'b0;
            base_q   <= '0;
        end else begin
            state_q  <= state_d;
            last_d_q <= last_d_d;
            base_q   <= base_d;
        end
    end

    // Grant in IDLE, beat/done pulses and burst termination.
    always_comb begin
        state_d  = state_q;
        last_d_d = last_d_q;
        base_d   = base_q;
        cnt_inc  = 1'b0;
        cnt_clr  = 1'b0;
        rd_c     = 1'b0;
        wr_c     = 1'b0;
        i_beat   = 1'b0;
        i_done   = 1'b0;
        d_beat   = 1'b0;
        d_done   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cnt_clr = 1'b1;
                // On a tie D wins unless it had the previous grant.
                if (d_pend && (!i_pend || !last_d_q)) begin
                    state_d  = d_wr ? ST_D_WR : ST_D_RD;
                    last_d_d = 1'b1;
                    base_d   = d_addr[ADDR_W-1:LINE_W];
                end else if (i_pend) begin
                    state_d  = ST_I_RD;
                    last_d_d = 1'b0;
                    base_d   = i_addr[ADDR_W-1:LINE_W];
                end
            end
            ST_I_RD: begin
                rd_c = 1'b1;
                if (mem.m_ack) begin
                    cnt_inc = 1'b1;
                    i_beat  = 1'b1;
                    i_done  = cnt_last;
                    if (cnt_last) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_D_RD, ST_D_WR: begin
                rd_c = (state_q == ST_D_RD);
                wr_c = (state_q == ST_D_WR);
                if (mem.m_ack) begin
                    cnt_inc = 1'b1;
                    d_beat  = 1'b1;
                    d_done  = cnt_last;
                    if (cnt_last) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign mem.m_rd    = rd_c;
    assign mem.m_wr    = wr_c;
    assign mem.m_addr  = (rd_c | wr_c) ? {base_q, cnt, {OFF_W{1'b0}}} : '0;
    assign mem.m_wdata = wr_c ? d_wdata : '0;

    assign i_rdata = mem.m_rdata;
    assign d_rdata = mem.m_rdata;

    // Stall flags drop in the done cycle so the pipeline restarts promptly.
    assign i_busy    = i_req & ~i_done;
    assign d_busy_rd = d_rd & ~d_wr & ~d_done;
    assign d_busy_wr = d_wr & ~d_done;

endmodule
